// File: rtl/ascii_receiver_cmd_if.sv
// ascii_receiver_cmd_if
//   Bundles the UART byte stream and the decoded command outputs of the
//   ASCII command decoder.
//   rx_done/rx_data           : byte strobe and data from uart_rx
//   set_hour/set_min/set_sec  : last accepted time, with time_set strobe
//   alarm_hour/alarm_min      : last accepted alarm, with alarm_set strobe
//   dht_req                   : request a DHT report transmission
//   cmd_err                   : line rejected
//   Modports: master = byte source / result consumer, slave = decoder.
interface ascii_receiver_cmd_if;
    logic       rx_done;
    logic [7:0] rx_data;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       time_set;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       alarm_set;
    logic       dht_req;
    logic       cmd_err;

    modport master (
        output rx_done, rx_data,
        input  set_hour, set_min, set_sec, time_set,
        input  alarm_hour, alarm_min, alarm_set, dht_req, cmd_err
    );

    modport slave (
        input  rx_done, rx_data,
        output set_hour, set_min, set_sec, time_set,
        output alarm_hour, alarm_min, alarm_set, dht_req, cmd_err
    );
endinterface

// File: rtl/ascii_receiver_cmd.sv
// ascii_receiver_cmd
//   Collects ASCII bytes from the UART into a line terminated by '\n' and
//   decodes "T=HH:MM:SS", "A=HH:MM" and "D" into one-cycle strobes with held
//   values. Malformed or overlong lines produce a one-cycle cmd_err.
//   clk   : system clock
//   rst_n : asynchronous reset, active-low
//   bus   : slave side of ascii_receiver_cmd_if (bytes in, results out)
module ascii_receiver_cmd #(
    parameter int MAX_LEN = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ascii_receiver_cmd_if.slave  bus
);
    localparam int IDX_W = $clog2(MAX_LEN + 1);
    localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(MAX_LEN);
    localparam logic [IDX_W-1:0] LEN_T    = IDX_W'(10);
    localparam logic [IDX_W-1:0] LEN_A    = IDX_W'(7);
    localparam logic [IDX_W-1:0] LEN_D    = IDX_W'(1);

    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_T     = "T";
    localparam logic [7:0] CH_A     = "A";
    localparam logic [7:0] CH_D     = "D";
    localparam logic [7:0] CH_EQ    = "=";
    localparam logic [7:0] CH_COLON = ":";

    typedef enum logic [1:0] {COLLECT, PARSE, DISCARD} state_t;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic [6:0] dec2(input logic [7:0] t, input logic [7:0] o);
        return 7'((t - 8'h30) * 8'd10 + (o - 8'h30));
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       line_q [MAX_LEN];
    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;

    logic       time_d, alarm_d, dht_d, err_d;
    logic       time_set_q, alarm_set_q, dht_req_q, cmd_err_q;
    logic [4:0] set_hour_q, alarm_hour_q;
    logic [5:0] set_min_q, set_sec_q, alarm_min_q;

    logic       byte_ok, is_lf;
    logic [6:0] hh, mm, ss;
    logic       t_ok, a_ok, d_ok;

    assign byte_ok = bus.rx_done && (bus.rx_data != CH_CR);
    assign is_lf   = (bus.rx_data == CH_LF);

    // Both command formats put the hour digits at 2..3 and minutes at 5..6.
    assign hh = dec2(line_q[2], line_q[3]);
    assign mm = dec2(line_q[5], line_q[6]);
    assign ss = dec2(line_q[8], line_q[9]);

    assign t_ok = (idx_q == LEN_T) && (line_q[0] == CH_T) && (line_q[1] == CH_EQ)
               && (line_q[4] == CH_COLON) && (line_q[7] == CH_COLON)
               && is_digit(line_q[2]) && is_digit(line_q[3])
               && is_digit(line_q[5]) && is_digit(line_q[6])
               && is_digit(line_q[8]) && is_digit(line_q[9])
               && (hh <= 7'd23) && (mm <= 7'd59) && (ss <= 7'd59);

    assign a_ok = (idx_q == LEN_A) && (line_q[0] == CH_A) && (line_q[1] == CH_EQ)
               && (line_q[4] == CH_COLON)
               && is_digit(line_q[2]) && is_digit(line_q[3])
               && is_digit(line_q[5]) && is_digit(line_q[6])
               && (hh <= 7'd23) && (mm <= 7'd59);

    assign d_ok = (idx_q == LEN_D) && (line_q[0] == CH_D);

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latch).
        state_d = state_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        wr_addr = idx_q;
        time_d  = 1'b0;
        alarm_d = 1'b0;
        dht_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            COLLECT: begin
                if (byte_ok) begin
                    if (is_lf) begin
                        if (idx_q != '0) state_d = PARSE;
                    end else if (idx_q == IDX_FULL) begin
                        state_d = DISCARD;
                    end else begin
                        wr_en = 1'b1;
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PARSE: begin
                // A zero length can only come from DISCARD, so it lands in cmd_err
                // with the same latency as any other rejected line.
                time_d  = t_ok;
                alarm_d = a_ok;
                dht_d   = d_ok;
                err_d   = !(t_ok || a_ok || d_ok);
                idx_d   = '0;
                state_d = COLLECT;
                if (byte_ok && !is_lf) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    idx_d   = IDX_W'(1);
                end
            end
            DISCARD: begin
                if (byte_ok && is_lf) begin
                    idx_d   = '0;
                    state_d = PARSE;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = COLLECT;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= COLLECT;
            idx_q        <= '0;
            time_set_q   <= 1'b0;
            alarm_set_q  <= 1'b0;
            dht_req_q    <= 1'b0;
            cmd_err_q    <= 1'b0;
            set_hour_q   <= '0;
            set_min_q    <= '0;
            set_sec_q    <= '0;
            alarm_hour_q <= '0;
            alarm_min_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            time_set_q  <= time_d;
            alarm_set_q <= alarm_d;
            dht_req_q   <= dht_d;
            cmd_err_q   <= err_d;
            if (time_d) begin
                set_hour_q <= hh[4:0];
                set_min_q  <= mm[5:0];
                set_sec_q  <= ss[5:0];
            end
            if (alarm_d) begin
                alarm_hour_q <= hh[4:0];
                alarm_min_q  <= mm[5:0];
            end
        end
    end

    // NOTE: the line buffer has no reset; only entries below idx_q are ever decoded.
    always_ff @(posedge clk) begin
        if (wr_en) line_q[wr_addr] <= bus.rx_data;
    end

    assign bus.time_set   = time_set_q;
    assign bus.alarm_set  = alarm_set_q;
    assign bus.dht_req    = dht_req_q;
    assign bus.cmd_err    = cmd_err_q;
    assign bus.set_hour   = set_hour_q;
    assign bus.set_min    = set_min_q;
    assign bus.set_sec    = set_sec_q;
    assign bus.alarm_hour = alarm_hour_q;
    assign bus.alarm_min  = alarm_min_q;
endmodule
